// File: rtl/ast_wr_pkg.sv
// Shared types and byte-count helpers for the Avalon-ST width reducer.
// Helpers take byte counts as arguments so they stay independent of any one instance.
`timescale 1ns/1ps
package ast_wr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Narrow beats needed to carry vbytes valid bytes (ceiling division).
    function automatic int calc_beats(input int vbytes, input int beat_bytes);
        return (vbytes + beat_bytes - 1) / beat_bytes;
    endfunction

    // Unused MSB bytes left in the final narrow beat.
    function automatic int calc_empty(input int nbeats, input int vbytes, input int beat_bytes);
        return nbeats * beat_bytes - vbytes;
    endfunction

endpackage

// File: rtl/ast_width_reducer.sv
// Avalon-ST width reducer: one wide word per sink handshake, emitted LSB-first
// as narrow beats; the final word of a packet is trimmed according to snk_empty.
`timescale 1ns/1ps
module ast_width_reducer
    import ast_wr_pkg::*;
#(
    parameter int DATA_IN_W   = 64,
    parameter int EMPTY_IN_W  = $clog2(DATA_IN_W / 8),
    parameter int CHANNEL_W   = 10,
    parameter int DATA_OUT_W  = 16,
    parameter int EMPTY_OUT_W = (DATA_OUT_W > 8) ? $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [DATA_IN_W-1:0]   snk_data,
    input  logic                   snk_startofpacket,
    input  logic                   snk_endofpacket,
    input  logic                   snk_valid,
    input  logic [EMPTY_IN_W-1:0]  snk_empty,
    input  logic [CHANNEL_W-1:0]   snk_channel,
    output logic                   snk_ready,
    output logic [DATA_OUT_W-1:0]  src_data,
    output logic                   src_startofpacket,
    output logic                   src_endofpacket,
    output logic                   src_valid,
    output logic [EMPTY_OUT_W-1:0] src_empty,
    output logic [CHANNEL_W-1:0]   src_channel,
    input  logic                   src_ready
);

    localparam int N         = DATA_IN_W / DATA_OUT_W;
    localparam int BYTES_IN  = DATA_IN_W / 8;
    localparam int BYTES_OUT = DATA_OUT_W / 8;
    localparam int CNT_W     = $clog2(N) + 1;

    if (DATA_IN_W % DATA_OUT_W != 0) begin : g_bad_ratio
        $error("DATA_IN_W must be a multiple of DATA_OUT_W");
    end
    if (DATA_OUT_W % 8 != 0) begin : g_bad_out_w
        $error("DATA_OUT_W must be a multiple of 8");
    end
    if (N < 2) begin : g_bad_n
        $error("DATA_IN_W / DATA_OUT_W must be at least 2");
    end

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ready_en_q;
    logic [DATA_IN_W-1:0]   data_q, data_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [CHANNEL_W-1:0]   chan_q, chan_d;
    logic [CNT_W-1:0]       nbeats_q, nbeats_d;
    logic [EMPTY_OUT_W-1:0] lempty_q, lempty_d;

    int   vbytes;
    int   ld_nbeats;
    logic last_beat;
    logic src_fire;
    logic snk_fire;

    // Handshakes: a transfer happens on a side exactly when its valid and ready
    // are both high at a rising clk edge; valid never waits on ready, and a
    // presented beat holds every src_* field until it is taken.
    assign src_valid = (state_q == SEND);
    assign last_beat = (cnt_q == nbeats_q - CNT_W'(1));
    assign src_fire  = src_valid & src_ready;
    assign snk_ready = ready_en_q & ((state_q == IDLE) | (src_fire & last_beat));
    assign snk_fire  = snk_valid & snk_ready;

    always_comb begin
        vbytes    = snk_endofpacket ? (BYTES_IN - int'(snk_empty)) : BYTES_IN;
        ld_nbeats = calc_beats(vbytes, BYTES_OUT);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        chan_d   = chan_q;
        nbeats_d = nbeats_q;
        lempty_d = lempty_q;
        // snk_ready only rises when the buffer is empty or draining its last
        // beat, so a sink accept always takes priority and reloads the buffer.
        if (snk_fire) begin
            state_d  = SEND;
            cnt_d    = '0;
            data_d   = snk_data;
            sop_d    = snk_startofpacket;
            eop_d    = snk_endofpacket;
            chan_d   = snk_channel;
            nbeats_d = CNT_W'(ld_nbeats);
            lempty_d = EMPTY_OUT_W'(calc_empty(ld_nbeats, vbytes, BYTES_OUT));
        end else if (src_fire) begin
            if (last_beat) begin
                state_d = IDLE;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                data_d = data_q >> DATA_OUT_W;
            end
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    // Payload registers carry no reset; they are only observed while in SEND.
    always_ff @(posedge clk) begin
        data_q   <= data_d;
        sop_q    <= sop_d;
        eop_q    <= eop_d;
        chan_q   <= chan_d;
        nbeats_q <= nbeats_d;
        lempty_q <= lempty_d;
    end

    assign src_data          = data_q[DATA_OUT_W-1:0];
    assign src_startofpacket = src_valid & sop_q & (cnt_q == '0);
    assign src_endofpacket   = src_valid & eop_q & last_beat;
    assign src_empty         = src_endofpacket ? lempty_q : '0;
    assign src_channel       = chan_q;

endmodule

// File: tb/tb_ast_width_reducer.sv
// Randomized scoreboard bench for ast_width_reducer (64-bit in, 16-bit out).
`timescale 1ns/1ps
module tb_ast_width_reducer;

  localparam int DIN  = 64;
  localparam int DOUT = 16;
  localparam int EIN  = 3;
  localparam int EOUT = 1;
  localparam int CW   = 10;
  localparam int BI   = DIN / 8;
  localparam int BO   = DOUT / 8;
  localparam int W    = DOUT + 3 + EOUT + CW - 1;

  logic            clk = 1'b0;
  logic            srst = 1'b0;
  logic [DIN-1:0]  snk_data = '0;
  logic            snk_startofpacket = 1'b0;
  logic            snk_endofpacket = 1'b0;
  logic            snk_valid = 1'b0;
  logic [EIN-1:0]  snk_empty = '0;
  logic [CW-1:0]   snk_channel = '0;
  logic            snk_ready;
  logic [DOUT-1:0] src_data;
  logic            src_startofpacket;
  logic            src_endofpacket;
  logic            src_valid;
  logic [EOUT-1:0] src_empty;
  logic [CW-1:0]   src_channel;
  logic            src_ready = 1'b1;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         armed = 1'b0;
  int           rdy_mode = 0;
  logic         stall_hold = 1'b0;
  logic [W-1:0] held;

  ast_width_reducer #(
    .DATA_IN_W(DIN), .EMPTY_IN_W(EIN), .CHANNEL_W(CW),
    .DATA_OUT_W(DOUT), .EMPTY_OUT_W(EOUT)
  ) dut (
    .clk(clk), .srst(srst),
    .snk_data(snk_data), .snk_startofpacket(snk_startofpacket),
    .snk_endofpacket(snk_endofpacket), .snk_valid(snk_valid),
    .snk_empty(snk_empty), .snk_channel(snk_channel), .snk_ready(snk_ready),
    .src_data(src_data), .src_startofpacket(src_startofpacket),
    .src_endofpacket(src_endofpacket), .src_valid(src_valid),
    .src_empty(src_empty), .src_channel(src_channel), .src_ready(src_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: slice the valid bytes of a wide word into narrow beats.
  task automatic push_word(input logic [DIN-1:0] d, input logic sop, input logic eop,
                           input logic [EIN-1:0] emp, input logic [CW-1:0] ch);
    int vb;
    int nb;
    logic [DOUT-1:0] piece;
    logic            eop_k;
    logic [EOUT-1:0] emp_k;
    vb = eop ? BI - int'(emp) : BI;
    nb = (vb + BO - 1) / BO;
    for (int k = 0; k < nb; k++) begin
      piece = d[k*DOUT +: DOUT];
      eop_k = eop && (k == nb - 1);
      emp_k = eop_k ? EOUT'(nb * BO - vb) : '0;
      exp_q.push_back({piece, sop && (k == 0), eop_k, emp_k, ch});
    end
  endtask

  always @(posedge clk) begin
    if (!srst && snk_valid && snk_ready)
      push_word(snk_data, snk_startofpacket, snk_endofpacket, snk_empty, snk_channel);
    armed = !srst;
  end

  always @(posedge clk) begin
    if (snk_valid && snk_endofpacket)
      assert (int'(snk_empty) < BI) else $error("illegal snk_empty driven");
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: src_ready = 1'b1;
      1: src_ready = ($urandom_range(0, 3) != 0);
      default: src_ready = ~src_ready;
    endcase
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    logic         exp_rdy;
    act = {src_data, src_startofpacket, src_endofpacket, src_empty, src_channel};
    if (srst) begin
      check("rst_src_valid", src_valid, 0);
      check("rst_src_sop", src_startofpacket, 0);
      check("rst_src_eop", src_endofpacket, 0);
      check("rst_snk_ready", snk_ready, 0);
      stall_hold = 1'b0;
    end else begin
      if (stall_hold) begin
        check("stall_valid", src_valid, 1);
        check("stall_hold", act, held);
      end
      if (armed) begin
        exp_rdy = (exp_q.size() == 0) || (src_valid && src_ready && exp_q.size() == 1);
        check("snk_ready", snk_ready, exp_rdy);
      end
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: unexpected beat %0h at %0t", act, $time);
        end else begin
          exp = exp_q.pop_front();
          check("beat", act, exp);
        end
      end
      stall_hold = src_valid && !src_ready;
      held = act;
    end
  end

  // driver tasks (entered at posedge+1)
  task automatic send_word(input logic [DIN-1:0] d, input logic sop, input logic eop,
                           input logic [EIN-1:0] emp, input logic [CW-1:0] ch);
    logic acc;
    int   guard;
    snk_data = d;
    snk_startofpacket = sop;
    snk_endofpacket = eop;
    snk_empty = emp;
    snk_channel = ch;
    snk_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = snk_ready && !srst;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 200) begin
        timeout_fail("snk_accept");
        break;
      end
    end
    snk_valid = 1'b0;
  endtask

  task automatic send_packet(input int nw, input logic [EIN-1:0] last_emp, input logic [CW-1:0] ch);
    for (int w = 0; w < nw; w++)
      send_word({$urandom, $urandom}, w == 0, w == nw - 1,
                (w == nw - 1) ? last_emp : EIN'($urandom_range(0, BI - 1)), ch);
  endtask

  task automatic check_run(input int n);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!src_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < n; i++) begin
      check("run_valid", src_valid, 1);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || src_valid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 srst = 1'b1;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(posedge clk);
    #1;

    // single word, full width
    fork
      send_word(64'h0011_2233_4455_6677, 1'b1, 1'b1, 3'd0, 10'h3a);
      check_run(4);
    join
    wait_idle();

    // last word with 3 valid bytes, then 1 valid byte
    send_packet(2, 3'd5, 10'h101);
    wait_idle();
    send_word(64'hdead_beef_cafe_f00d, 1'b1, 1'b1, 3'd7, 10'h2c5);
    wait_idle();

    // three back-to-back words, no bubbles
    fork
      send_packet(3, 3'd0, 10'h077);
      check_run(12);
    join
    wait_idle();

    // alternating backpressure
    rdy_mode = 2;
    send_packet(1, 3'd0, 10'h155);
    wait_idle();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // reset after beat 1 of a 4-beat word
    send_word(64'h1111_2222_3333_4444, 1'b1, 1'b0, 3'd0, 10'h0f0);
    @(posedge clk);
    @(posedge clk);
    #2 srst = 1'b1;
    #1;
    check("async_rst_valid", src_valid, 0);
    check("async_rst_sop", src_startofpacket, 0);
    exp_q.delete();
    @(posedge clk);
    #1 srst = 1'b0;
    @(posedge clk);
    #1;
    send_packet(2, 3'd1, 10'h222);
    wait_idle();

    // randomized traffic with random backpressure
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      send_packet($urandom_range(1, 4), EIN'($urandom_range(0, BI - 1)), CW'($urandom));
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
    end
    rdy_mode = 0;
    wait_idle();
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
